// File: rtl/vga_cap_pkg.sv
// ============================================================================
// Module      : vga_cap_pkg
// Description : Shared types, default geometry and helpers for the VGA
//               frame capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_cap_pkg;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BURST_LEN_DEF = 8;
  localparam int FRAME_PIXELS  = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int BURST_W       = $clog2(BURST_LEN_DEF) + 1;

  typedef logic [31:0] pix_word_t;

  typedef enum logic [2:0] {
    CAP_IDLE    = 3'd0,
    CAP_ARMED   = 3'd1,
    CAP_CAPTURE = 3'd2,
    CAP_DRAIN   = 3'd3,
    CAP_ABORT   = 3'd4
  } cap_state_t;

  typedef enum logic [0:0] {
    MST_IDLE  = 1'b0,
    MST_BURST = 1'b1
  } mst_state_t;

  function automatic pix_word_t pack_pixel(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {8'h00, r, g, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_cap_fifo.sv
// ============================================================================
// Module      : vga_cap_fifo
// Description : Synchronous show-ahead pixel FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_cap_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [31:0]              i_data,
  input  logic                     i_pop,
  output logic [31:0]              o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Caller guarantees a push is only issued when a slot is free this cycle.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/vga_frame_capture.sv
// ============================================================================
// Module      : vga_frame_capture
// Description : VGA stream sink; packs active pixels and bursts whole frames
//               into memory over an Avalon-MM write master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_frame_capture import vga_cap_pkg::*; #(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [7:0]                    vga_red,
  input  logic [7:0]                    vga_green,
  input  logic [7:0]                    vga_blue,
  input  logic                          vga_hs,
  input  logic                          vga_vs,
  input  logic                          vga_blank,
  input  logic                          pix_en,
  input  logic                          cap_enable,
  input  logic [ADDR_W-1:0]             frame_base,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  output logic [3:0]                    avm_byteenable,
  output logic [$clog2(BURST_LEN):0]    avm_burstcount,
  input  logic                          avm_waitrequest,
  output logic                          frame_done,
  output logic                          overflow
);

  localparam int N_PIX = H_ACTIVE * V_ACTIVE;
  localparam int PC_W  = $clog2(N_PIX + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BC_W  = $clog2(BURST_LEN) + 1;

  cap_state_t        r_cap_state, w_cap_next;
  mst_state_t        r_mst_state, w_mst_next;
  logic              r_vs_prev;
  logic [PC_W-1:0]   r_pix_cnt;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_burst_addr;
  logic [BC_W-1:0]   r_burst_cnt;
  logic [BC_W-1:0]   r_beats_left;

  logic              w_sof, w_pop, w_pix_req, w_push_ok, w_push, w_reject;
  logic              w_wr_done, w_frame_done, w_start_frame, w_start_burst;
  logic [BC_W-1:0]   w_burst_len;
  logic [31:0]       w_fifo_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_unused;

  assign w_unused = ^{vga_hs, frame_base[1:0]};

  assign w_sof     = pix_en && r_vs_prev && !vga_vs;
  assign w_pop     = (r_mst_state == MST_BURST) && !avm_waitrequest;
  assign w_pix_req = (r_cap_state == CAP_CAPTURE) && pix_en && vga_blank && cap_enable && !w_sof;
  // A full FIFO still takes a pixel when the master frees a slot the same cycle.
  assign w_push_ok = (w_fifo_count < CNT_W'(FIFO_DEPTH)) || w_pop;
  assign w_push    = w_pix_req && w_push_ok;
  assign w_reject  = w_pix_req && !w_push_ok;
  assign w_wr_done = w_fifo_empty && (r_mst_state == MST_IDLE);
  assign w_start_frame = (r_cap_state == CAP_ARMED) && (w_cap_next == CAP_CAPTURE);

  vga_cap_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_push  (w_push),
    .i_data  (pack_pixel(vga_red, vga_green, vga_blue)),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_cap_next   = r_cap_state;
    w_frame_done = 1'b0;
    case (r_cap_state)
      CAP_IDLE:    if (cap_enable) w_cap_next = CAP_ARMED;
      CAP_ARMED: begin
        if (!cap_enable)  w_cap_next = CAP_IDLE;
        else if (w_sof)   w_cap_next = CAP_CAPTURE;
      end
      CAP_CAPTURE: begin
        if (w_reject)
          w_cap_next = CAP_ABORT;
        else if (w_sof || !cap_enable || (w_push && r_pix_cnt == PC_W'(N_PIX - 1)))
          w_cap_next = CAP_DRAIN;
      end
      CAP_DRAIN: if (w_wr_done) begin
        w_frame_done = 1'b1;
        w_cap_next   = cap_enable ? CAP_ARMED : CAP_IDLE;
      end
      CAP_ABORT: if (w_wr_done) w_cap_next = cap_enable ? CAP_ARMED : CAP_IDLE;
      default:     w_cap_next = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_cap_state <= CAP_IDLE;
      r_vs_prev   <= 1'b0;
      r_pix_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_cap_state <= w_cap_next;
      if (pix_en) r_vs_prev <= vga_vs;
      if (w_start_frame) begin
        r_pix_cnt  <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push)   r_pix_cnt  <= r_pix_cnt + PC_W'(1);
        if (w_reject) r_overflow <= 1'b1;
      end
    end
  end

  assign w_burst_len = (w_fifo_count >= CNT_W'(BURST_LEN)) ? BC_W'(BURST_LEN)
                                                            : BC_W'(w_fifo_count);

  always_comb begin
    w_mst_next    = r_mst_state;
    w_start_burst = 1'b0;
    case (r_mst_state)
      MST_IDLE: begin
        if ((w_fifo_count >= CNT_W'(BURST_LEN)) ||
            (!w_fifo_empty && (r_cap_state == CAP_DRAIN || r_cap_state == CAP_ABORT))) begin
          w_mst_next    = MST_BURST;
          w_start_burst = 1'b1;
        end
      end
      MST_BURST: if (w_pop && r_beats_left == BC_W'(1)) w_mst_next = MST_IDLE;
      default:   w_mst_next = MST_IDLE;
    endcase
  end

  // The next-burst address advances when a burst is issued, not when it ends.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_mst_state  <= MST_IDLE;
      r_next_addr  <= '0;
      r_burst_addr <= '0;
      r_burst_cnt  <= '0;
      r_beats_left <= '0;
    end else begin
      r_mst_state <= w_mst_next;
      if (w_start_frame) r_next_addr <= {frame_base[ADDR_W-1:2], 2'b00};
      if (w_start_burst) begin
        r_burst_addr <= r_next_addr;
        r_burst_cnt  <= w_burst_len;
        r_beats_left <= w_burst_len;
        r_next_addr  <= r_next_addr + {{(ADDR_W-BC_W-2){1'b0}}, w_burst_len, 2'b00};
      end else if (w_pop) begin
        r_beats_left <= r_beats_left - BC_W'(1);
      end
    end
  end

  assign avm_write      = (r_mst_state == MST_BURST);
  assign avm_address    = r_burst_addr;
  assign avm_burstcount = r_burst_cnt;
  assign avm_writedata  = avm_write ? w_fifo_head : 32'h0;
  assign avm_byteenable = 4'hF;
  assign overflow       = r_overflow;
  assign frame_done     = w_frame_done && !reset_reset;

endmodule

`default_nettype wire
